// File: rtl/arb_mux_n_if.sv
// arb_mux_n_if: stream bus between NUM_CH producers, the mux and one consumer
interface arb_mux_n_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH)
);
  logic [NUM_CH*WIDTH-1:0] i_data;
  logic [NUM_CH-1:0]       i_valid;
  logic [NUM_CH-1:0]       o_ready;
  logic [SEL_W-1:0]        i_sel;
  logic [SEL_W-1:0]        o_ch;
  logic [WIDTH-1:0]        o_data;
  logic                    o_valid;
  logic                    i_ready;
  modport slave  (input i_data, i_valid, i_sel, i_ready, output o_ready, o_data, o_ch, o_valid);
  modport master (output i_data, i_valid, i_sel, i_ready, input o_ready, o_data, o_ch, o_valid);
endinterface

// File: rtl/arb_mux_n.sv
// arb_mux_n: N-channel registered stream mux, external select or round-robin
module arb_mux_n #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter int SEL_W  = $clog2(NUM_CH),
  parameter int MODE   = 0
) (
  input logic         i_clk,
  input logic         i_rst_n,
  arb_mux_n_if.slave  bus
);
  localparam int PAD = 1 << SEL_W;
  logic [SEL_W-1:0] r_ch, r_ptr, w_gnt, w_rr_gnt;
  logic [WIDTH-1:0] r_data;
  logic             r_valid, w_load, w_gnt_vld, w_rr_vld, w_sel_vld;
  logic [PAD-1:0]   w_valid_pad;
  logic [WIDTH-1:0] w_ch_data [PAD];
  // padding to a power of two keeps out-of-range selects harmless
  for (genvar k = 0; k < PAD; k++) begin : g_ch
    if (k < NUM_CH) begin : g_in
      assign w_ch_data[k] = bus.i_data[k*WIDTH +: WIDTH];
    end else begin : g_pad
      assign w_ch_data[k] = '0;
    end
  end
  assign w_valid_pad = PAD'(bus.i_valid);
  assign w_load      = !r_valid || bus.i_ready;
  assign w_sel_vld   = w_valid_pad[bus.i_sel] && (int'(bus.i_sel) < NUM_CH);
  always_comb begin
    w_rr_gnt = r_ptr;
    w_rr_vld = 1'b0;
    for (int i = 1; i <= NUM_CH; i++)
      if (!w_rr_vld && w_valid_pad[SEL_W'((int'(r_ptr) + i) % NUM_CH)]) begin
        w_rr_gnt = SEL_W'((int'(r_ptr) + i) % NUM_CH);
        w_rr_vld = 1'b1;
      end
  end
  assign w_gnt       = MODE == 1 ? w_rr_gnt : bus.i_sel;
  assign w_gnt_vld   = MODE == 1 ? w_rr_vld : w_sel_vld;
  assign bus.o_ready = (w_load && w_gnt_vld) ? NUM_CH'(1) << w_gnt : '0;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ch    <= '0;
      r_ptr   <= SEL_W'(NUM_CH - 1);
    end else if (w_load) begin
      r_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_data <= w_ch_data[w_gnt];
        r_ch   <= w_gnt;
        if (MODE == 1) r_ptr <= w_gnt;
      end
    end
  assign bus.o_data  = r_data;
  assign bus.o_ch    = r_ch;
  assign bus.o_valid = r_valid;
endmodule

// File: tb/tb_arb_mux_n.sv
// tb_arb_mux_n: scoreboard bench for select, round-robin and 3-channel configs
module tb_arb_mux_n;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [33:0] q0[$], q1[$], q2[$];
  arb_mux_n_if #(.WIDTH(32), .NUM_CH(4)) b0 ();
  arb_mux_n_if #(.WIDTH(32), .NUM_CH(4)) b1 ();
  arb_mux_n_if #(.WIDTH(32), .NUM_CH(3)) b2 ();
  arb_mux_n #(.WIDTH(32), .NUM_CH(4), .MODE(0)) u0 (.i_clk(clk), .i_rst_n(rst_n), .bus(b0));
  arb_mux_n #(.WIDTH(32), .NUM_CH(4), .MODE(1)) u1 (.i_clk(clk), .i_rst_n(rst_n), .bus(b1));
  arb_mux_n #(.WIDTH(32), .NUM_CH(3), .MODE(0)) u2 (.i_clk(clk), .i_rst_n(rst_n), .bus(b2));
  always #5 clk = ~clk;
  function automatic void chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, a, e);
    end
  endfunction
  function automatic void extra(input string n, input logic [63:0] a);
    checks++;
    errors++;
    $display("FAIL %s unexpected item %0h", n, a);
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (rst_n && b0.o_valid && b0.i_ready) begin
      if (q0.size() == 0) extra("sb0", {b0.o_ch, b0.o_data});
      else chk("sb0", {b0.o_ch, b0.o_data}, q0.pop_front());
    end
  always @(negedge clk)
    if (rst_n && b1.o_valid && b1.i_ready) begin
      if (q1.size() == 0) extra("sb1", {b1.o_ch, b1.o_data});
      else chk("sb1", {b1.o_ch, b1.o_data}, q1.pop_front());
    end
  always @(negedge clk)
    if (rst_n && b2.o_valid && b2.i_ready) begin
      if (q2.size() == 0) extra("sb2", {b2.o_ch, b2.o_data});
      else chk("sb2", {b2.o_ch, b2.o_data}, q2.pop_front());
    end
  initial begin
    b0.i_data = '0; b0.i_valid = '0; b0.i_sel = '0; b0.i_ready = 1'b0;
    b1.i_data = '0; b1.i_valid = '0; b1.i_sel = '0; b1.i_ready = 1'b0;
    b2.i_data = '0; b2.i_valid = '0; b2.i_sel = '0; b2.i_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid0", b0.o_valid, 0);
    chk("rst_data1", b1.o_data, 0);
    chk("rst_ch1", b1.o_ch, 0);
    tick();
    rst_n = 1'b1;
    b0.i_sel = 2; b0.i_data[64 +: 32] = 32'hDEAD_BEEF; b0.i_valid = 4'b0100; b0.i_ready = 1'b1;
    q0.push_back({2'd2, 32'hDEAD_BEEF});
    @(negedge clk);
    chk("sel_ready", b0.o_ready, 4'b0100);
    tick();
    b0.i_sel = 1;
    @(negedge clk);
    chk("sel_ready_none", b0.o_ready, 0);
    chk("sel_valid", b0.o_valid, 1);
    tick();
    @(negedge clk);
    chk("drain_valid", b0.o_valid, 0);
    chk("drain_data_hold", b0.o_data, 32'hDEAD_BEEF);
    chk("drain_ch_hold", b0.o_ch, 2);
    tick();
    b0.i_sel = 0; b0.i_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      b0.i_data[31:0] = 32'h100 + i;
      q0.push_back({2'd0, 32'h100 + i});
      @(negedge clk);
      if (i > 0) chk("b2b_no_bubble", b0.o_valid, 1);
      chk("b2b_ready", b0.o_ready, 4'b0001);
      tick();
    end
    b0.i_valid = 0;
    @(negedge clk);
    chk("b2b_last", {b0.o_valid, b0.o_data}, {1'b1, 32'h103});
    tick();
    @(negedge clk);
    chk("b2b_empty", b0.o_valid, 0);
    tick();
    for (int k = 0; k < 4; k++) b1.i_data[k*32 +: 32] = 32'hA0 + k;
    b1.i_valid = 4'b1111; b1.i_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      q1.push_back({2'(i % 4), 32'hA0 + (i % 4)});
      tick();
    end
    b1.i_valid = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      q1.push_back(i % 2 == 0 ? {2'd1, 32'hA1} : {2'd3, 32'hA3});
      tick();
    end
    for (int k = 0; k < 4; k++) b1.i_data[k*32 +: 32] = 32'h10 + k;
    b1.i_valid = 4'b0010;
    q1.push_back({2'd1, 32'h11});
    tick();
    b1.i_ready = 1'b0; b1.i_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_ready", b1.o_ready, 0);
      chk("stall_data", b1.o_data, 32'h11);
      chk("stall_ch", {b1.o_valid, b1.o_ch}, {1'b1, 2'd1});
      tick();
    end
    b1.i_ready = 1'b1;
    @(negedge clk);
    chk("stall_next_gnt", b1.o_ready, 4'b0100);
    q1.push_back({2'd2, 32'h12});
    tick();
    b1.i_valid = 0;
    tick();
    b1.i_valid = 4'b0001;
    tick();
    b1.i_ready = 1'b0; b1.i_valid = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", b1.o_valid, 0);
    chk("async_rst_data", b1.o_data, 0);
    chk("async_rst_ch", b1.o_ch, 0);
    tick();
    rst_n = 1'b1;
    b1.i_valid = 4'b1111; b1.i_ready = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt0", b1.o_ready, 4'b0001);
    q1.push_back({2'd0, 32'h10});
    tick();
    @(negedge clk);
    chk("post_rst_gnt1", b1.o_ready, 4'b0010);
    q1.push_back({2'd1, 32'h11});
    tick();
    b1.i_valid = 0;
    tick();
    for (int k = 0; k < 3; k++) b2.i_data[k*32 +: 32] = 32'hC0 + k;
    b2.i_valid = 3'b111; b2.i_ready = 1'b1; b2.i_sel = 3;
    @(negedge clk);
    chk("oor_ready", b2.o_ready, 0);
    tick();
    @(negedge clk);
    chk("oor_no_xfer", b2.o_valid, 0);
    tick();
    b2.i_sel = 2;
    q2.push_back({2'd2, 32'hC2});
    @(negedge clk);
    chk("sel3_ready", b2.o_ready, 3'b100);
    tick();
    b2.i_valid = 0;
    tick();
    tick();
    chk("q0_empty", q0.size(), 0);
    chk("q1_empty", q1.size(), 0);
    chk("q2_empty", q2.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-channel registered stream multiplexer: the successor to the combinational 4:1 datapath mux. It selects one of `NUM_CH` valid/ready input channels, either by an external select (`MODE=0`) or by round-robin arbitration (`MODE=1`), and presents the winner through a single output register with a valid/ready handshake. It sits between multi-source producers (e.g. writeback or memory-response sources) and a single consumer that may stall.

## Interface

Parameters:
- `WIDTH`, 32: data width per channel.
- `NUM_CH`, 4: channel count, ≥ 2.
- `SEL_W`, `$clog2(NUM_CH)`: select/channel-index width.
- `MODE`, 0: 0 = external select, 1 = round-robin.

Ports:
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low.
- `i_data`  in  `NUM_CH*WIDTH`  channel k occupies bits `[k*WIDTH +: WIDTH]`.
- `i_valid`  in  `NUM_CH`  per-channel valid.
- `o_ready`  out  `NUM_CH`  per-channel ready; combinational.
- `i_sel`  in  `SEL_W`  channel select; used only when `MODE=0`.
- `o_data`  out  `WIDTH`  registered output data.
- `o_ch`  out  `SEL_W`  index of the channel that produced `o_data`.
- `o_valid`  out  1  output register holds a valid item.
- `i_ready`  in  1  consumer accepts the output this cycle.

## Operation

**Load condition**
- `load_en = !o_valid || i_ready`: the output register is empty or is being drained this cycle.

**Grant, MODE=0**
- `gnt = i_sel`.
- `gnt_vld = i_valid[i_sel] && (i_sel < NUM_CH)`.
- An out-of-range `i_sel` grants nothing.

**Grant, MODE=1**
- Search channels `rr_ptr+1, rr_ptr+2, …` modulo `NUM_CH`, wrapping.
- The first channel with `i_valid` set wins.
- `gnt_vld` is the OR of `i_valid`.

**Input handshake**
- `o_ready[k] = load_en && gnt_vld && (gnt == k)`.
- At most one bit of `o_ready` is set.
- A non-granted channel sees `o_ready = 0` and must hold its data.

**Transfer in** (`load_en && gnt_vld`), at the next edge:
- `o_data <= i_data[gnt]`, `o_ch <= gnt`, `o_valid <= 1`.
- `MODE=1`: `rr_ptr <= gnt`.

**Drain without refill** (`o_valid && i_ready && !gnt_vld`):
- `o_valid <= 0`.
- `o_data` and `o_ch` hold their last values.

**Stall** (`o_valid && !i_ready`):
- All registers hold.
- `o_ready = 0` on every channel.

**Pointer rule**
- `rr_ptr` advances only on an input transfer.
- A stall never rotates priority.

**Reset** (`i_rst_n` low, asynchronous):
- `o_valid = 0`, `o_data = 0`, `o_ch = 0`.
- `rr_ptr = NUM_CH-1`, so channel 0 has top priority after reset.
- Reset asserted mid-transfer discards the held item; no partial state survives.

## Timing

- Latency: an input accepted at edge n appears on `o_data`/`o_valid` after edge n.
- Throughput: one item per cycle while `i_ready` stays high.
- Simultaneous drain and refill in one cycle: the new item replaces the old with no bubble.
- Combinational paths:
  - `i_ready` → `o_ready`.
  - `i_valid`/`i_sel` → `o_ready`.
- Registered outputs: `o_data`, `o_ch`, `o_valid`; none depends combinationally on inputs.
- Fairness, `MODE=1`: with all channels continuously valid and `i_ready = 1`, the grant order is 0, 1, …, `NUM_CH-1`, 0, …; each channel is served once per `NUM_CH` transfers.

## Test plan

1. **Reset.** Assert `i_rst_n = 0` mid-stream with `o_valid = 1` → `o_valid = 0`, `o_data = 0`, `o_ch = 0` immediately. After release, `MODE=1` with all valid grants ch0 first.
2. **External select** (`MODE=0`, `NUM_CH=4`, `WIDTH=32`). Stimulus: `i_sel = 2`, `i_data[2] = 32'hDEAD_BEEF`, `i_valid = 4'b0100`, `i_ready = 1` → `o_ready = 4'b0100`; next cycle `o_data = 32'hDEAD_BEEF`, `o_ch = 2`, `o_valid = 1`. Setting `i_sel = 1` with `i_valid[1] = 0` → no `o_ready` bit set, and `o_valid` falls after the drain.
3. **Round-robin** (`MODE=1`, all four valid, `i_ready = 1`, 8 cycles) → `o_ch` sequence 0, 1, 2, 3, 0, 1, 2, 3. With `i_valid = 4'b1010` → 1, 3, 1, 3.
4. **Backpressure.** `o_valid = 1`, `o_data = 32'h11`, `i_ready = 0` for 3 cycles with new inputs valid → `o_data` stays `32'h11`, `o_ready = 0`, `rr_ptr` unchanged. After `i_ready` rises, the next grant follows the unchanged pointer.
5. **Back-to-back drain/refill.** `i_ready = 1` continuously with a single channel always valid → `o_valid` stays 1 every cycle and `o_data` updates every cycle with no bubble.
6. **Out-of-range select** (`MODE=0`, `NUM_CH=3`, `i_sel = 3`, all valid) → `o_ready = 3'b000` and no transfer.
